traffic_conflict_monitor: RTL and testbench

Safety monitor that sits directly downstream of the two intersection light controllers: direction A (phase flag 1) and direction B (phase flag 0). It observes both controllers' car and walker lamp vectors every clock. It checks encoding, cross-direction conflicts, walker/car consistency, sequence order, yellow length and stuck lamps. It drives the registered lamp outputs to the physical drivers, and on any violation it latches a fault and forces flashing red until cleared.

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/traffic_seq_checker.sv | 97 +++++++++
 rtl/traffic_conflict_monitor.sv | 154 +++++++++++++++
 tb/tb_traffic_conflict_monitor.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings, fault codes and state types for the intersection safety monitor.
package traffic_pkg;

    localparam logic [3:0] C_RED    = 4'b1000;
    localparam logic [3:0] C_YELLOW = 4'b0100;
    localparam logic [3:0] C_LEFT   = 4'b0010;
    localparam logic [3:0] C_GREEN  = 4'b0001;
    localparam logic [3:0] C_NONE   = 4'b0000;

    localparam logic [1:0] W_RED   = 2'b10;
    localparam logic [1:0] W_GREEN = 2'b01;
    localparam logic [1:0] W_NONE  = 2'b00;

    localparam logic [2:0] F_NONE     = 3'd0;
    localparam logic [2:0] F_ENCODING = 3'd1;
    localparam logic [2:0] F_CONFLICT = 3'd2;
    localparam logic [2:0] F_WALK     = 3'd3;
    localparam logic [2:0] F_TRANS    = 3'd4;
    localparam logic [2:0] F_YELLOW   = 3'd5;
    localparam logic [2:0] F_HOLD     = 3'd6;

    typedef enum logic [1:0] {StIdle, StRun, StFault} top_state_e;

    typedef enum logic [2:0] {
        TrkIdle, TrkGreen, TrkY1, TrkLeft, TrkY2, TrkRed
    } trk_state_e;

    // Cars that let traffic into the intersection.
    function automatic logic is_moving(logic [3:0] car);
        return (car == C_GREEN) || (car == C_LEFT) || (car == C_YELLOW);
    endfunction

endpackage

// File: rtl/traffic_seq_checker.sv
// Per-direction lamp sequence tracker: encoding, walker, transition, yellow length and hold checks.
module traffic_seq_checker
    import traffic_pkg::*;
#(
    parameter int unsigned YELLOW_LEN = 2,
    parameter int unsigned MAX_HOLD   = 40
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en_i,
    input  logic [3:0] car_i,
    input  logic [1:0] walk_i,
    output logic       v_enc_o,
    output logic       v_walk_o,
    output logic       v_trans_o,
    output logic       v_yellow_o,
    output logic       v_hold_o
);
    trk_state_e trk_q, trk_d;
    logic       first_q, first_d;
    logic [6:0] hold_q, hold_d, yel_q, yel_d;
    logic [3:0] held_val;
    logic       same;

    always_comb begin
        unique case (trk_q)
            TrkGreen:     held_val = C_GREEN;
            TrkY1, TrkY2: held_val = C_YELLOW;
            TrkLeft:      held_val = C_LEFT;
            TrkRed:       held_val = C_RED;
            default:      held_val = C_NONE;
        endcase
    end

    assign same     = (trk_q != TrkIdle) && (car_i == held_val);
    assign v_enc_o  = en_i && (($countones(car_i) > 1) || (walk_i == 2'b11));
    assign v_walk_o = en_i && (walk_i != W_RED) && (car_i != C_RED);

    always_comb begin
        trk_d      = trk_q;
        first_d    = first_q;
        hold_d     = hold_q;
        yel_d      = yel_q;
        v_trans_o  = 1'b0;
        v_yellow_o = 1'b0;
        v_hold_o   = 1'b0;
        if (!en_i) begin
            trk_d   = TrkIdle;
            first_d = 1'b0;
            hold_d  = '0;
            yel_d   = '0;
        end else if (same) begin
            hold_d = (hold_q == 7'd127) ? hold_q : hold_q + 7'd1;
            if (car_i == C_YELLOW) yel_d = (yel_q == 7'd127) ? yel_q : yel_q + 7'd1;
            v_hold_o = !first_q && (hold_q >= 7'(MAX_HOLD));
        end else begin
            hold_d     = 7'd1;
            yel_d      = (car_i == C_YELLOW) ? 7'd1 : 7'd0;
            first_d    = (trk_q == TrkIdle);
            v_yellow_o = !first_q && (held_val == C_YELLOW) && (yel_q != 7'(YELLOW_LEN));
            unique case (trk_q)
                TrkIdle: begin
                    if (car_i == C_GREEN)       trk_d = TrkGreen;
                    else if (car_i == C_YELLOW) trk_d = TrkY1;
                    else if (car_i == C_RED)    trk_d = TrkRed;
                    else                        v_trans_o = 1'b1;
                end
                TrkGreen: if (car_i == C_YELLOW) trk_d = TrkY1; else v_trans_o = 1'b1;
                // An opening yellow may have followed either green or left.
                TrkY1: begin
                    if (car_i == C_LEFT)                trk_d = TrkLeft;
                    else if (car_i == C_RED && first_q) trk_d = TrkRed;
                    else                                v_trans_o = 1'b1;
                end
                TrkLeft: if (car_i == C_YELLOW) trk_d = TrkY2; else v_trans_o = 1'b1;
                TrkY2:   if (car_i == C_RED) trk_d = TrkRed; else v_trans_o = 1'b1;
                TrkRed:  if (car_i == C_GREEN) trk_d = TrkGreen; else v_trans_o = 1'b1;
                default: v_trans_o = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trk_q   <= TrkIdle;
            first_q <= 1'b0;
            hold_q  <= '0;
            yel_q   <= '0;
        end else begin
            trk_q   <= trk_d;
            first_q <= first_d;
            hold_q  <= hold_d;
            yel_q   <= yel_d;
        end
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Intersection safety monitor: registers lamp drive, prioritises violations, latches fault
// and flashes red until cleared.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned YELLOW_LEN = 2,
    parameter int unsigned MAX_HOLD   = 40,
    parameter int unsigned FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_start,
    input  logic       i_clear,
    input  logic [3:0] i_car_a,
    input  logic [3:0] i_car_b,
    input  logic [1:0] i_walk_a,
    input  logic [1:0] i_walk_b,
    output logic [3:0] o_car_a,
    output logic [3:0] o_car_b,
    output logic [1:0] o_walk_a,
    output logic [1:0] o_walk_b,
    output logic       o_fault,
    output logic [2:0] o_fault_code,
    output logic       o_fault_dir
);
    top_state_e state_q, state_d;
    logic [3:0] car_a_q, car_a_d, car_b_q, car_b_d;
    logic [1:0] walk_a_q, walk_a_d, walk_b_q, walk_b_d;
    logic       fault_q, fault_d, dir_q, dir_d, flash_on_q, flash_on_d;
    logic [2:0] code_q, code_d;
    logic [7:0] flash_cnt_q, flash_cnt_d;
    logic       chk_en, viol_dir;
    logic [2:0] viol_code;
    logic [5:0] va, vb;   // bit k flags fault code k+1

    // Checks also cover the cycle on which start is first seen in IDLE.
    assign chk_en = i_start && (state_q != StFault);
    assign va[1]  = chk_en && is_moving(i_car_a) && is_moving(i_car_b);
    assign vb[1]  = 1'b0;

    traffic_seq_checker #(.YELLOW_LEN(YELLOW_LEN), .MAX_HOLD(MAX_HOLD)) u_seq_a (
        .clk(clk), .reset_n(reset_n), .en_i(chk_en), .car_i(i_car_a), .walk_i(i_walk_a),
        .v_enc_o(va[0]), .v_walk_o(va[2]), .v_trans_o(va[3]), .v_yellow_o(va[4]),
        .v_hold_o(va[5])
    );

    traffic_seq_checker #(.YELLOW_LEN(YELLOW_LEN), .MAX_HOLD(MAX_HOLD)) u_seq_b (
        .clk(clk), .reset_n(reset_n), .en_i(chk_en), .car_i(i_car_b), .walk_i(i_walk_b),
        .v_enc_o(vb[0]), .v_walk_o(vb[2]), .v_trans_o(vb[3]), .v_yellow_o(vb[4]),
        .v_hold_o(vb[5])
    );

    // Scan high to low so the lowest code, and direction A within it, is kept.
    always_comb begin
        viol_code = F_NONE;
        viol_dir  = 1'b0;
        for (int k = 5; k >= 0; k--) begin
            if (va[k] || vb[k]) begin
                viol_code = 3'(k + 1);
                viol_dir  = !va[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        fault_d     = fault_q;
        code_d      = code_q;
        dir_d       = dir_q;
        flash_cnt_d = flash_cnt_q;
        flash_on_d  = flash_on_q;
        car_a_d     = C_NONE;
        car_b_d     = C_NONE;
        walk_a_d    = W_NONE;
        walk_b_d    = W_NONE;
        unique case (state_q)
            StIdle, StRun: begin
                if (!i_start) begin
                    state_d = StIdle;
                end else if (viol_code != F_NONE) begin
                    state_d     = StFault;
                    fault_d     = 1'b1;
                    code_d      = viol_code;
                    dir_d       = viol_dir;
                    flash_cnt_d = '0;
                    flash_on_d  = 1'b1;
                    car_a_d     = C_RED;
                    car_b_d     = C_RED;
                end else begin
                    state_d  = StRun;
                    car_a_d  = i_car_a;
                    car_b_d  = i_car_b;
                    walk_a_d = i_walk_a;
                    walk_b_d = i_walk_b;
                end
            end
            StFault: begin
                if (i_clear && !i_start) begin
                    state_d     = StIdle;
                    fault_d     = 1'b0;
                    code_d      = F_NONE;
                    dir_d       = 1'b0;
                    flash_cnt_d = '0;
                    flash_on_d  = 1'b0;
                end else begin
                    if (flash_cnt_q == 8'(FLASH_HALF - 1)) begin
                        flash_cnt_d = '0;
                        flash_on_d  = !flash_on_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q + 8'd1;
                    end
                    car_a_d = flash_on_d ? C_RED : C_NONE;
                    car_b_d = flash_on_d ? C_RED : C_NONE;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            car_a_q     <= C_NONE;
            car_b_q     <= C_NONE;
            walk_a_q    <= W_NONE;
            walk_b_q    <= W_NONE;
            fault_q     <= 1'b0;
            code_q      <= F_NONE;
            dir_q       <= 1'b0;
            flash_cnt_q <= '0;
            flash_on_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            car_a_q     <= car_a_d;
            car_b_q     <= car_b_d;
            walk_a_q    <= walk_a_d;
            walk_b_q    <= walk_b_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
            dir_q       <= dir_d;
            flash_cnt_q <= flash_cnt_d;
            flash_on_q  <= flash_on_d;
        end
    end

    assign o_car_a      = car_a_q;
    assign o_car_b      = car_b_q;
    assign o_walk_a     = walk_a_q;
    assign o_walk_b     = walk_b_q;
    assign o_fault      = fault_q;
    assign o_fault_code = code_q;
    assign o_fault_dir  = dir_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Randomised bench for traffic_conflict_monitor against a rule-level reference model.
module tb_traffic_conflict_monitor;
    import traffic_pkg::*;

    localparam int YELLOW_LEN = 2;
    localparam int MAX_HOLD   = 40;
    localparam int FLASH_HALF = 4;

    logic       clk = 1'b0;
    logic       reset_n, start, clear;
    logic [3:0] car_a, car_b, o_car_a, o_car_b;
    logic [1:0] walk_a, walk_b, o_walk_a, o_walk_b;
    logic       o_fault, o_fault_dir;
    logic [2:0] o_fault_code;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state: mode 0 idle, 1 run, 2 fault.
    int         m_mode, m_fcyc;
    logic [2:0] m_code;
    logic       m_dir;
    bit         m_started [2];
    bit         m_first [2];
    logic [3:0] m_prev [2];
    int         m_len [2];
    int         m_pos [2];
    logic [16:0] exp_vec;
    logic [7:0]  sched [$];

    traffic_conflict_monitor #(
        .YELLOW_LEN(YELLOW_LEN), .MAX_HOLD(MAX_HOLD), .FLASH_HALF(FLASH_HALF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_start(start), .i_clear(clear),
        .i_car_a(car_a), .i_car_b(car_b), .i_walk_a(walk_a), .i_walk_b(walk_b),
        .o_car_a(o_car_a), .o_car_b(o_car_b), .o_walk_a(o_walk_a), .o_walk_b(o_walk_b),
        .o_fault(o_fault), .o_fault_code(o_fault_code), .o_fault_dir(o_fault_dir)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] obs();
        return {o_fault, o_fault_code, o_fault_dir, o_car_a, o_car_b, o_walk_a, o_walk_b};
    endfunction

    // Legal cycle as a list: GREEN, YELLOW, LEFT, YELLOW, RED.
    function automatic logic [3:0] seq_val(int p);
        case (p)
            0: return C_GREEN;
            1: return C_YELLOW;
            2: return C_LEFT;
            3: return C_YELLOW;
            default: return C_RED;
        endcase
    endfunction

    function automatic bit moving(logic [3:0] c);
        return (c == C_GREEN) || (c == C_LEFT) || (c == C_YELLOW);
    endfunction

    function automatic logic [5:0] dir_mask(int d, logic [3:0] car, logic [1:0] walk);
        logic [5:0] m = '0;
        m[0] = ($countones(car) > 1) || (walk == 2'b11);
        m[2] = (walk != W_RED) && (car != C_RED);
        if (!m_started[d]) begin
            m[3] = !((car == C_GREEN) || (car == C_YELLOW) || (car == C_RED));
        end else if (car == m_prev[d]) begin
            m[5] = !m_first[d] && (m_len[d] + 1 > MAX_HOLD);
        end else begin
            if (m_pos[d] < 0) m[3] = !((car == C_LEFT) || (car == C_RED));
            else              m[3] = (car != seq_val((m_pos[d] + 1) % 5));
            m[4] = (m_prev[d] == C_YELLOW) && !m_first[d] && (m_len[d] != YELLOW_LEN);
        end
        return m;
    endfunction

    task automatic trk_update(int d, logic [3:0] car);
        if (!m_started[d]) begin
            m_started[d] = 1'b1;
            m_first[d]   = 1'b1;
            m_len[d]     = 1;
            m_pos[d]     = (car == C_GREEN) ? 0 : (car == C_RED) ? 4 : -1;
        end else if (car == m_prev[d]) begin
            m_len[d]++;
        end else begin
            m_first[d] = 1'b0;
            m_len[d]   = 1;
            m_pos[d]   = (m_pos[d] < 0) ? ((car == C_LEFT) ? 2 : 4) : (m_pos[d] + 1) % 5;
        end
        m_prev[d] = car;
    endtask

    task automatic model_clear();
        m_mode = 0;
        m_code = 3'd0;
        m_dir  = 1'b0;
        m_fcyc = 0;
        exp_vec = '0;
        for (int d = 0; d < 2; d++) begin
            m_started[d] = 1'b0;
            m_first[d]   = 1'b0;
            m_prev[d]    = C_NONE;
            m_len[d]     = 0;
            m_pos[d]     = 0;
        end
    endtask

    task automatic model_step();
        logic [5:0] ma, mb;
        int         code;
        logic       dir, on;
        if (m_mode == 2) begin
            if (clear && !start) begin
                model_clear();
            end else begin
                m_fcyc++;
                on = ((m_fcyc / FLASH_HALF) % 2) == 0;
                exp_vec = {1'b1, m_code, m_dir, on ? C_RED : C_NONE, on ? C_RED : C_NONE,
                           W_NONE, W_NONE};
            end
        end else if (!start) begin
            model_clear();
        end else begin
            ma = dir_mask(0, car_a, walk_a);
            mb = dir_mask(1, car_b, walk_b);
            ma[1] = moving(car_a) && moving(car_b);
            code = 0;
            dir  = 1'b0;
            for (int k = 1; k <= 6; k++) begin
                if (code == 0 && (ma[k-1] || mb[k-1])) begin
                    code = k;
                    dir  = !ma[k-1];
                end
            end
            if (code != 0) begin
                m_mode = 2;
                m_code = 3'(code);
                m_dir  = dir;
                m_fcyc = 0;
                exp_vec = {1'b1, m_code, m_dir, C_RED, C_RED, W_NONE, W_NONE};
            end else begin
                m_mode = 1;
                trk_update(0, car_a);
                trk_update(1, car_b);
                exp_vec = {1'b0, 3'd0, 1'b0, car_a, car_b, walk_a, walk_b};
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [1:0] rand_walk(logic [3:0] car);
        return (car == C_RED && $urandom_range(0, 1) == 1) ? W_GREEN : W_RED;
    endfunction

    task automatic push_run(int dd, logic [3:0] v, int n);
        for (int i = 0; i < n; i++) sched.push_back(dd == 0 ? {v, C_RED} : {C_RED, v});
    endtask

    // Two conforming controllers: A (flag 1) moves first, B waits red, then swap.
    task automatic gen_sched(int n);
        sched.delete();
        while (sched.size() < n) begin
            for (int dd = 0; dd < 2; dd++) begin
                push_run(dd, C_GREEN, $urandom_range(1, 10));
                push_run(dd, C_YELLOW, YELLOW_LEN);
                push_run(dd, C_LEFT, $urandom_range(1, 10));
                push_run(dd, C_YELLOW, YELLOW_LEN);
                push_run(dd, C_RED, $urandom_range(1, 4));
            end
        end
    endtask

    task automatic drive_sched(int i);
        car_a  = sched[i][7:4];
        car_b  = sched[i][3:0];
        walk_a = rand_walk(car_a);
        walk_b = rand_walk(car_b);
    endtask

    task automatic go_idle();
        start = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b1;
        car_a = C_GREEN; car_b = C_GREEN; walk_a = W_GREEN; walk_b = W_GREEN;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (obs() !== 17'd0) begin
            n_fail++;
            $display("FAIL reset: got %h expected %h", obs(), 17'd0);
        end
        #3 reset_n = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            car_a = 4'($urandom); car_b = 4'($urandom);
            tick();
            n_tests++;
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL idle: cycle %0d got %h expected %h", cyc, obs(), exp_vec);
            end
        end
    endtask

    task automatic test_normal();
        gen_sched(300);
        start = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive_sched(i);
            tick();
            n_tests++;
            if (obs() !== exp_vec || o_fault !== 1'b0) begin
                n_fail++;
                $display("FAIL normal: cycle %0d got %h expected %h", cyc, obs(), exp_vec);
            end
        end
        go_idle();
        n_tests++;
        if (obs() !== 17'd0) begin
            n_fail++;
            $display("FAIL normal_stop: got %h expected %h", obs(), 17'd0);
        end
    endtask

    task automatic test_conflict();
        gen_sched(60);
        start = 1'b1;
        for (int i = 0; i <= 50; i++) begin
            drive_sched(i);
            if (i == 50) begin
                car_a = C_GREEN; car_b = C_GREEN; walk_a = W_RED; walk_b = W_RED;
            end
            tick();
            n_tests++;
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL conflict_seq: cycle %0d got %h expected %h", cyc, obs(), exp_vec);
            end
        end
        n_tests++;
        if (obs() !== {1'b1, 3'd2, 1'b0, 4'b1000, 4'b1000, 2'b00, 2'b00}) begin
            n_fail++;
            $display("FAIL conflict_code: got %h expected %h", obs(),
                     {1'b1, 3'd2, 1'b0, 4'b1000, 4'b1000, 2'b00, 2'b00});
        end
        go_idle();
    endtask

    task automatic test_priority();
        logic [3:0] want;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4; i++) begin
                start  = 1'b1;
                car_a  = (i < 3) ? C_GREEN : C_LEFT;
                car_b  = C_RED;
                walk_a = W_RED;
                walk_b = (pass == 1 && i == 3) ? 2'b11 : W_RED;
                tick();
                n_tests++;
                if (obs() !== exp_vec) begin
                    n_fail++;
                    $display("FAIL priority_seq: cycle %0d got %h expected %h", cyc, obs(), exp_vec);
                end
            end
            want = (pass == 0) ? {3'd4, 1'b0} : {3'd1, 1'b1};
            n_tests++;
            if ({o_fault_code, o_fault_dir} !== want) begin
                n_fail++;
                $display("FAIL priority_code: pass %0d got %h expected %h", pass,
                         {o_fault_code, o_fault_dir}, want);
            end
            go_idle();
        end
    endtask

    task automatic test_yellow_len();
        int ylens [3] = '{3, 2, 1};
        for (int t = 0; t < 3; t++) begin
            start = 1'b1; car_b = C_RED; walk_a = W_RED; walk_b = W_RED;
            for (int i = 0; i < 2 + ylens[t] + 1; i++) begin
                car_a = (i < 2) ? C_GREEN : (i < 2 + ylens[t]) ? C_YELLOW : C_LEFT;
                tick();
                n_tests++;
                if (obs() !== exp_vec) begin
                    n_fail++;
                    $display("FAIL yellow_seq: cycle %0d got %h expected %h", cyc, obs(), exp_vec);
                end
            end
            n_tests++;
            if (o_fault !== (ylens[t] != YELLOW_LEN) ||
                o_fault_code !== ((ylens[t] != YELLOW_LEN) ? 3'd5 : 3'd0)) begin
                n_fail++;
                $display("FAIL yellow_len: len %0d got fault %b code %0d", ylens[t], o_fault,
                         o_fault_code);
            end
            go_idle();
        end
    endtask

    task automatic test_hold();
        int rlens [2] = '{41, 40};
        for (int t = 0; t < 2; t++) begin
            start = 1'b1; car_b = C_RED; walk_a = W_RED; walk_b = W_RED;
            for (int i = 0; i < 8 + rlens[t] + 1; i++) begin
                if (i < 8)                  car_a = seq_val(i / 2);
                else if (i < 8 + rlens[t])  car_a = C_RED;
                else                        car_a = C_GREEN;
                tick();
                n_tests++;
                if (obs() !== exp_vec) begin
                    n_fail++;
                    $display("FAIL hold_seq: cycle %0d got %h expected %h", cyc, obs(), exp_vec);
                end
            end
            n_tests++;
            if (o_fault_code !== ((rlens[t] > MAX_HOLD) ? 3'd6 : 3'd0)) begin
                n_fail++;
                $display("FAIL hold_len: len %0d got code %0d", rlens[t], o_fault_code);
            end
            go_idle();
        end
    endtask

    task automatic test_flash();
        start = 1'b1; clear = 1'b0;
        car_a = C_GREEN; car_b = C_GREEN; walk_a = W_RED; walk_b = W_RED;
        tick();
        clear = 1'b1;
        for (int k = 0; k < 20; k++) begin
            car_a = 4'($urandom); car_b = 4'($urandom);
            tick();
            n_tests++;
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL flash: cycle %0d got %h expected %h", cyc, obs(), exp_vec);
            end
        end
        n_tests++;
        if (o_fault !== 1'b1 || o_fault_code !== 3'd2) begin
            n_fail++;
            $display("FAIL flash_hold: got fault %b code %0d expected 1 2", o_fault, o_fault_code);
        end
        go_idle();
        n_tests++;
        if (obs() !== 17'd0) begin
            n_fail++;
            $display("FAIL flash_exit: got %h expected %h", obs(), 17'd0);
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        car_a = C_GREEN; car_b = C_GREEN; walk_a = W_RED; walk_b = W_RED;
        for (int k = 0; k < 6; k++) tick();
        #3 reset_n = 1'b0;
        #1;
        model_clear();
        n_tests++;
        if (obs() !== 17'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", obs(), 17'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        car_b = C_RED; walk_a = W_RED; walk_b = W_RED;
        for (int i = 0; i < 10; i++) begin
            car_a = (i == 0) ? C_YELLOW : C_RED;
            tick();
            n_tests++;
            if (obs() !== exp_vec || o_fault !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_restart: cycle %0d got %h expected %h", cyc, obs(), exp_vec);
            end
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        gen_sched(420);
        for (int c = 0; c < 400; c++) begin
            if (m_mode == 2 && m_fcyc >= 3) begin
                start = 1'b0;
                clear = 1'b1;
            end else begin
                start = ($urandom_range(0, 99) != 0);
                clear = 1'($urandom_range(0, 1));
                drive_sched(idx);
                if ($urandom_range(0, 24) == 0) begin
                    case ($urandom_range(0, 3))
                        0: car_a  = 4'($urandom);
                        1: car_b  = 4'($urandom);
                        2: walk_a = 2'($urandom);
                        default: walk_b = 2'($urandom);
                    endcase
                end
            end
            idx = start ? idx + 1 : 0;
            tick();
            n_tests++;
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL random: cycle %0d got %h expected %h", cyc, obs(), exp_vec);
            end
        end
        go_idle();
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0; clear = 1'b0;
        car_a = C_NONE; car_b = C_NONE; walk_a = W_NONE; walk_b = W_NONE;
        #2;
        test_reset();
        test_normal();
        test_conflict();
        test_priority();
        test_yellow_len();
        test_hold();
        test_flash();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
